conv_stream_tx: RTL and testbench

Transmitter that feeds the convolution engine's streaming input. A host preloads an input matrix and a kernel into two internal 16x16 buffers through a random-access write port. On `start`, the block replays both buffers in row-major order, one element per clock, matching the engine's stream-in order: all matrix elements first, then all kernel elements with no gap. It sits directly in front of the convolution block and drives its matrix and kernel data inputs.

---
 rtl/conv_stream_tx.sv | 181 ++++++++++++++++++
 tb/tb_conv_stream_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_tx.sv
// conv_stream_tx
// Stream transmitter for the convolution engine input. A host fills a matrix
// buffer and a kernel buffer (each 2^DIM_W x 2^DIM_W) through a random-access
// write port while the block is idle. On start, the block replays the active
// region of the matrix row-major, one element per clock, then the active region
// of the kernel with no gap, then pulses done.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   wr_en/wr_sel        buffer write strobe / select (0 matrix, 1 kernel)
//   wr_row/wr_col       write address
//   wr_data             write data
//   in_row/in_col       matrix rows-1 / cols-1
//   ker_row/ker_col     kernel rows-1 / cols-1
//   start               begin a transfer (only honoured in IDLE)
//   busy                high while streaming
//   done                one-cycle pulse after the last kernel element
//   mat_valid/mat_data  matrix element stream (data is 0 when not valid)
//   ker_valid/ker_data  kernel element stream (data is 0 when not valid)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; buffer writes accepted
// SEND_MAT | matBuf[rowCnt][colCnt] is on mat_data this cycle
// SEND_KER | kerBuf[rowCnt][colCnt] is on ker_data this cycle
// DONE     | done pulse is on the outputs this cycle
module conv_stream_tx #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [DIM_W-1:0]  wr_row,
  input  logic [DIM_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DIM_W-1:0]  in_row,
  input  logic [DIM_W-1:0]  in_col,
  input  logic [DIM_W-1:0]  ker_row,
  input  logic [DIM_W-1:0]  ker_col,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mat_valid,
  output logic [DATA_W-1:0] mat_data,
  output logic              ker_valid,
  output logic [DATA_W-1:0] ker_data
);

  localparam int DEPTH = 1 << DIM_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_MAT = 2'd1,
    SEND_KER = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, nextState;

  logic [DIM_W-1:0] rowCnt, colCnt, nextRow, nextCol;
  logic [DIM_W-1:0] inRowL, inColL, kerRowL, kerColL;

  logic [DATA_W-1:0] matBuf [DEPTH][DEPTH];
  logic [DATA_W-1:0] kerBuf [DEPTH][DEPTH];

  logic              busyNxt, doneNxt, matValidNxt, kerValidNxt;
  logic [DATA_W-1:0] matDataNxt, kerDataNxt;

  logic acceptStart;
  logic bufWrEn;

  assign acceptStart = (state == IDLE) && start;
  // start wins over a write on the same edge
  assign bufWrEn     = (state == IDLE) && wr_en && !start;

  // State, counters, latched dimensions and registered outputs.
  // Outputs are loaded from the next-state view so that element k appears in
  // the cycle right after edge E0+k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rowCnt    <= '0;
      colCnt    <= '0;
      inRowL    <= '0;
      inColL    <= '0;
      kerRowL   <= '0;
      kerColL   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mat_valid <= 1'b0;
      mat_data  <= '0;
      ker_valid <= 1'b0;
      ker_data  <= '0;
    end else begin
      state  <= nextState;
      rowCnt <= nextRow;
      colCnt <= nextCol;
      if (acceptStart) begin
        inRowL  <= in_row;
        inColL  <= in_col;
        kerRowL <= ker_row;
        kerColL <= ker_col;
      end
      busy      <= busyNxt;
      done      <= doneNxt;
      mat_valid <= matValidNxt;
      mat_data  <= matDataNxt;
      ker_valid <= kerValidNxt;
      ker_data  <= kerDataNxt;
    end
  end

  // Next state and traversal. End of row/region is detected by equality on the
  // current index before incrementing, so a full 16-wide dimension never wraps
  // early. In the IDLE->SEND_MAT step the dimensions are still being latched,
  // but the first element is always [0][0] so they are not needed yet.
  always_comb begin
    nextState = state;
    nextRow   = rowCnt;
    nextCol   = colCnt;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = SEND_MAT;
          nextRow   = '0;
          nextCol   = '0;
        end
      end
      SEND_MAT: begin
        if (colCnt == inColL) begin
          nextCol = '0;
          if (rowCnt == inRowL) begin
            nextRow   = '0;
            nextState = SEND_KER;
          end else begin
            nextRow = rowCnt + 1'b1;
          end
        end else begin
          nextCol = colCnt + 1'b1;
        end
      end
      SEND_KER: begin
        if (colCnt == kerColL) begin
          nextCol = '0;
          if (rowCnt == kerRowL) begin
            nextRow   = '0;
            nextState = DONE;
          end else begin
            nextRow = rowCnt + 1'b1;
          end
        end else begin
          nextCol = colCnt + 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    matValidNxt = (nextState == SEND_MAT);
    kerValidNxt = (nextState == SEND_KER);
    busyNxt     = matValidNxt || kerValidNxt;
    doneNxt     = (nextState == DONE);
    matDataNxt  = matValidNxt ? matBuf[nextRow][nextCol] : '0;
    kerDataNxt  = kerValidNxt ? kerBuf[nextRow][nextCol] : '0;
  end

  // Buffers are deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (bufWrEn) begin
      if (wr_sel) kerBuf[wr_row][wr_col] <= wr_data;
      else        matBuf[wr_row][wr_col] <= wr_data;
    end
  end

endmodule

// File: tb/tb_conv_stream_tx.sv
module tb_conv_stream_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel, start;
  logic [3:0] wr_row, wr_col, in_row, in_col, ker_row, ker_col;
  logic [7:0] wr_data;
  logic       busy, done, mat_valid, ker_valid;
  logic [7:0] mat_data, ker_data;

  int tests = 0;
  int fails = 0;

  logic       capMv   [0:1023];
  logic [7:0] capMd   [0:1023];
  logic       capKv   [0:1023];
  logic [7:0] capKd   [0:1023];
  logic       capBusy [0:1023];
  logic       capDone [0:1023];

  // expected per-cycle pattern for a 2x2 matrix / 1x1 kernel transfer
  logic       eMv [0:6];
  logic [7:0] eMd [0:6];
  logic       eKv [0:6];
  logic [7:0] eKd [0:6];
  logic       eBusy [0:6];
  logic       eDone [0:6];

  conv_stream_tx #(.DATA_W(8), .DIM_W(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .in_row(in_row), .in_col(in_col), .ker_row(ker_row), .ker_col(ker_col),
    .start(start), .busy(busy), .done(done),
    .mat_valid(mat_valid), .mat_data(mat_data),
    .ker_valid(ker_valid), .ker_data(ker_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // call at a negedge; the write lands on the following posedge
  task automatic writeElem(input logic sel, input int r, input int c, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 4'(r); wr_col = 4'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic setDims(input int ir, input int ic, input int kr, input int kc);
    in_row = 4'(ir); in_col = 4'(ic); ker_row = 4'(kr); ker_col = 4'(kc);
  endtask

  task automatic recordCycle(input int i);
    capMv[i] = mat_valid; capMd[i] = mat_data; capKv[i] = ker_valid;
    capKd[i] = ker_data;  capBusy[i] = busy;   capDone[i] = done;
  endtask

  task automatic capture(input int n, input bit dropStart);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      recordCycle(i);
      if (i == 0 && dropStart) start = 1'b0;
    end
  endtask

  // stream for mat {5A,01,10,11} / ker {00}
  task automatic setPatternA();
    eMv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    eMd   = '{8'h5A, 8'h01, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00};
    eKv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eKd   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    eBusy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    eDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    setDims(0, 0, 0, 0);
    #1;
    tests++;
    if ({busy, done, mat_valid, mat_data, ker_valid, ker_data} !== 20'h0) begin
      fails++;
      $display("FAIL reset_initial: got %h, expected 0", {busy, done, mat_valid, mat_data, ker_valid, ker_data});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, mat_valid, mat_data, ker_valid, ker_data} !== 20'h0) begin
      fails++;
      $display("FAIL reset_idle: got %h, expected 0", {busy, done, mat_valid, mat_data, ker_valid, ker_data});
    end
  endtask

  task automatic test_short();
    logic       sMv [0:6];
    logic [7:0] sMd [0:6];
    logic       sKv [0:6];
    logic [7:0] sKd [0:6];
    logic       sBusy [0:6];
    logic       sDone [0:6];
    int busyCnt;
    sMv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    sMd   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0};
    sKv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    sKd   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0};
    sBusy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    writeElem(1'b0, 0, 0, 8'd1);
    writeElem(1'b0, 0, 1, 8'd2);
    writeElem(1'b0, 1, 0, 8'd3);
    writeElem(1'b0, 1, 1, 8'd4);
    writeElem(1'b1, 0, 0, 8'd5);
    setDims(1, 1, 0, 0);
    start = 1'b1;
    capture(7, 1'b1);
    busyCnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (capBusy[i]) busyCnt++;
      tests++;
      if ({capMv[i], capMd[i], capKv[i], capKd[i], capBusy[i], capDone[i]} !==
          {sMv[i], sMd[i], sKv[i], sKd[i], sBusy[i], sDone[i]}) begin
        fails++;
        $display("FAIL short cycle %0d: got mv=%b md=%h kv=%b kd=%h busy=%b done=%b, expected mv=%b md=%h kv=%b kd=%h busy=%b done=%b",
                 i, capMv[i], capMd[i], capKv[i], capKd[i], capBusy[i], capDone[i],
                 sMv[i], sMd[i], sKv[i], sKd[i], sBusy[i], sDone[i]);
      end
    end
    tests++;
    if (busyCnt !== 5) begin
      fails++;
      $display("FAIL short_busy_len: got %0d, expected 5", busyCnt);
    end
  endtask

  task automatic test_full();
    int badMat, badKer, firstBad, doneCnt, busyCnt;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        writeElem(1'b0, r, c, 8'(r * 16 + c));
        writeElem(1'b1, r, c, 8'(r * 16 + c));
      end
    setDims(15, 15, 15, 15);
    start = 1'b1;
    capture(515, 1'b1);
    badMat = 0; badKer = 0; firstBad = -1; doneCnt = 0; busyCnt = 0;
    for (int k = 0; k < 515; k++) begin
      if (capDone[k]) doneCnt++;
      if (capBusy[k]) busyCnt++;
      if (k < 256) begin
        if ({capMv[k], capMd[k], capKv[k], capKd[k]} !== {1'b1, 8'(k), 1'b0, 8'd0}) begin
          badMat++;
          if (firstBad < 0) firstBad = k;
        end
      end else if (k < 512) begin
        if ({capMv[k], capMd[k], capKv[k], capKd[k]} !== {1'b0, 8'd0, 1'b1, 8'(k - 256)}) begin
          badKer++;
          if (firstBad < 0) firstBad = k;
        end
      end
    end
    tests++;
    if (badMat !== 0) begin
      fails++;
      $display("FAIL full_matrix_phase: got %0d bad cycles (first at %0d), expected 0", badMat, firstBad);
    end
    tests++;
    if (badKer !== 0) begin
      fails++;
      $display("FAIL full_kernel_phase: got %0d bad cycles (first at %0d), expected 0", badKer, firstBad);
    end
    tests++;
    if ({capMd[15], capMd[16]} !== {8'd15, 8'd16}) begin
      fails++;
      $display("FAIL full_row_wrap: got %0d,%0d, expected 15,16", capMd[15], capMd[16]);
    end
    tests++;
    if ({capKv[511], capKd[511]} !== {1'b1, 8'd255}) begin
      fails++;
      $display("FAIL full_last: got kv=%b kd=%0d, expected kv=1 kd=255", capKv[511], capKd[511]);
    end
    tests++;
    if (doneCnt !== 1 || capDone[512] !== 1'b1 || capBusy[512] !== 1'b0) begin
      fails++;
      $display("FAIL full_done: got count=%0d done@512=%b busy@512=%b, expected 1,1,0", doneCnt, capDone[512], capBusy[512]);
    end
    tests++;
    if (busyCnt !== 512) begin
      fails++;
      $display("FAIL full_busy_len: got %0d, expected 512", busyCnt);
    end
  endtask

  task automatic test_guard();
    int busyCnt, mvCnt, kvCnt;
    writeElem(1'b0, 0, 0, 8'h5A);
    setDims(1, 1, 0, 0);
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      recordCycle(i);
      if (i == 0) start = 1'b0;
      if (i == 1) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 4'd0; wr_col = 4'd0;
        wr_data = 8'hFF; in_row = 4'd0;
      end
      if (i == 3) begin
        start = 1'b0; wr_en = 1'b0; in_row = 4'd1;
      end
    end
    busyCnt = 0; mvCnt = 0; kvCnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (capBusy[i]) busyCnt++;
      if (capMv[i]) mvCnt++;
      if (capKv[i]) kvCnt++;
    end
    tests++;
    if (busyCnt !== 5 || mvCnt !== 4 || kvCnt !== 1 || capDone[5] !== 1'b1) begin
      fails++;
      $display("FAIL guard_length: got busy=%0d mv=%0d kv=%0d done@5=%b, expected 5,4,1,1", busyCnt, mvCnt, kvCnt, capDone[5]);
    end
    tests++;
    if ({capMd[2], capMd[3]} !== {8'h10, 8'h11}) begin
      fails++;
      $display("FAIL guard_stream: got %h %h, expected 10 11", capMd[2], capMd[3]);
    end
    start = 1'b1;
    capture(7, 1'b1);
    tests++;
    if ({capMv[0], capMd[0]} !== {1'b1, 8'h5A}) begin
      fails++;
      $display("FAIL guard_write_dropped: got mv=%b md=%h, expected mv=1 md=5a", capMv[0], capMd[0]);
    end
  endtask

  task automatic test_reset_mid();
    int sawActive;
    setPatternA();
    setDims(1, 1, 0, 0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      recordCycle(i);
      if (i == 0) start = 1'b0;
    end
    tests++;
    if ({capMv[2], capMd[2]} !== {1'b1, 8'h10}) begin
      fails++;
      $display("FAIL rstmid_pre: got mv=%b md=%h, expected mv=1 md=10", capMv[2], capMd[2]);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, mat_valid, mat_data, ker_valid, ker_data} !== 20'h0) begin
      fails++;
      $display("FAIL rstmid_async: got %h, expected 0", {busy, done, mat_valid, mat_data, ker_valid, ker_data});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sawActive = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) sawActive++;
    end
    tests++;
    if (sawActive !== 0) begin
      fails++;
      $display("FAIL rstmid_no_done: got %0d active cycles, expected 0", sawActive);
    end
    start = 1'b1;
    capture(7, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tests++;
      if ({capMv[i], capMd[i], capKv[i], capKd[i], capBusy[i], capDone[i]} !==
          {eMv[i], eMd[i], eKv[i], eKd[i], eBusy[i], eDone[i]}) begin
        fails++;
        $display("FAIL rstmid_restart cycle %0d: got mv=%b md=%h kv=%b busy=%b done=%b, expected mv=%b md=%h kv=%b busy=%b done=%b",
                 i, capMv[i], capMd[i], capKv[i], capBusy[i], capDone[i],
                 eMv[i], eMd[i], eKv[i], eBusy[i], eDone[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    setPatternA();
    setDims(1, 1, 0, 0);
    start = 1'b1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 4'd0; wr_col = 4'd1; wr_data = 8'hEE;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      recordCycle(i);
      if (i == 0) wr_en = 1'b0;
      if (i == 7) start = 1'b0;
    end
    for (int i = 0; i < 14; i++) begin
      tests++;
      if ({capMv[i], capMd[i], capKv[i], capKd[i], capBusy[i], capDone[i]} !==
          {eMv[i % 7], eMd[i % 7], eKv[i % 7], eKd[i % 7], eBusy[i % 7], eDone[i % 7]}) begin
        fails++;
        $display("FAIL b2b cycle %0d: got mv=%b md=%h kv=%b busy=%b done=%b, expected mv=%b md=%h kv=%b busy=%b done=%b",
                 i, capMv[i], capMd[i], capKv[i], capBusy[i], capDone[i],
                 eMv[i % 7], eMd[i % 7], eKv[i % 7], eBusy[i % 7], eDone[i % 7]);
      end
    end
    gap = 0;
    for (int i = 5; i < 14; i++) begin
      if (capBusy[i]) break;
      gap++;
    end
    tests++;
    if (gap !== 2) begin
      fails++;
      $display("FAIL b2b_gap: got %0d idle cycles, expected 2", gap);
    end
    tests++;
    if ({capMd[1], capMd[8]} !== {8'h01, 8'h01}) begin
      fails++;
      $display("FAIL b2b_collision_write: got %h %h, expected 01 01", capMd[1], capMd[8]);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_full();
    test_guard();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
